// File: rtl/mic_capture_ctrl_if.sv
// Sample stream from the capture controller to the feature-extraction front end.
// The master side drives the sample and its framing; the slave side returns ready.
interface mic_capture_ctrl_if;
  logic [15:0] smp;
  logic        smp_valid;
  logic        smp_ready;
  logic        frame_start;
  logic        frame_end;

  modport master (output smp, smp_valid, frame_start, frame_end, input smp_ready);
  modport slave  (input smp, smp_valid, frame_start, frame_end, output smp_ready);
endinterface

// File: rtl/mic_capture_ctrl.sv
// I2S microphone capture sequencer: drives the receiver's tick/enable, discards warm-up
// samples, then truncates 24-bit samples to 16 bits and frames them into a one-entry buffer.
module mic_capture_ctrl #(
  parameter int unsigned DIV       = 8,
  parameter int unsigned WARMUP    = 2048,
  parameter int unsigned FRAME_LEN = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      stop_i,
  output logic                      mic_enable_o,
  output logic                      mic_tick_o,
  input  logic [23:0]               mic_data_i,
  input  logic                      mic_rdy_i,
  mic_capture_ctrl_if.master        smp_if,
  output logic                      busy_o,
  output logic                      overrun_o
);

  localparam int unsigned TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned WW = $clog2(WARMUP + 1);
  localparam int unsigned FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WARMUP, ST_RUN, ST_DRAIN} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick_q, tick_d;
  logic [WW-1:0] warm_q, warm_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [15:0]   smp_q, smp_d;
  logic          valid_q, valid_d;
  logic          fs_q, fs_d;
  logic          fe_q, fe_d;
  logic          overrun_q, overrun_d;
  logic          handshake;
  logic          can_load;
  logic          load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      warm_q     <= '0;
      fcnt_q     <= '0;
      smp_q      <= '0;
      valid_q    <= 1'b0;
      fs_q       <= 1'b0;
      fe_q       <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      warm_q     <= warm_d;
      fcnt_q     <= fcnt_d;
      smp_q      <= smp_d;
      valid_q    <= valid_d;
      fs_q       <= fs_d;
      fe_q       <= fe_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    warm_d     = warm_q;
    fcnt_d     = fcnt_q;
    smp_d      = smp_q;
    valid_d    = valid_q;
    fs_d       = fs_q;
    fe_d       = fe_q;
    overrun_d  = overrun_q;
    can_load   = 1'b0;
    load       = 1'b0;
    handshake  = valid_q & smp_if.smp_ready;

    if (state_q != ST_IDLE) begin
      tick_cnt_d = (tick_cnt_q == TW'(DIV - 1)) ? '0 : tick_cnt_q + TW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d    = ST_WARMUP;
          overrun_d  = 1'b0;
          warm_d     = '0;
          fcnt_d     = '0;
          tick_cnt_d = '0;
        end
      end
      ST_WARMUP: begin
        if (stop_i) begin
          state_d = ST_IDLE;
        end else if (mic_rdy_i) begin
          warm_d = warm_q + WW'(1);
          if (warm_q == WW'(WARMUP - 1)) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        can_load = 1'b1;
        if (stop_i) begin
          if (fcnt_q == '0 && !valid_q) begin
            state_d  = ST_IDLE;
            can_load = 1'b0;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Once the frame_end sample is in the buffer the frame is complete; accept nothing more.
        can_load = (fcnt_q != '0);
        if (handshake && fe_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (mic_rdy_i && can_load) begin
      if (!valid_q || handshake) load = 1'b1;
      else                       overrun_d = 1'b1;
    end

    if (load) begin
      smp_d   = mic_data_i[23:8];
      valid_d = 1'b1;
      fs_d    = (fcnt_q == '0);
      fe_d    = (fcnt_q == FW'(FRAME_LEN - 1));
      fcnt_d  = (fcnt_q == FW'(FRAME_LEN - 1)) ? '0 : fcnt_q + FW'(1);
    end else if (handshake) begin
      valid_d = 1'b0;
    end

    tick_d = (state_d != ST_IDLE) && (tick_cnt_d == TW'(DIV - 1));
  end

  assign mic_enable_o       = (state_q != ST_IDLE);
  assign busy_o             = (state_q != ST_IDLE);
  assign mic_tick_o         = tick_q;
  assign overrun_o          = overrun_q;
  assign smp_if.smp         = smp_q;
  assign smp_if.smp_valid   = valid_q;
  assign smp_if.frame_start = fs_q;
  assign smp_if.frame_end   = fe_q;

endmodule

// File: doc/mic_capture_ctrl.md
Name: mic_capture_ctrl

Overview:
- Sequences the I2S microphone receiver: generates its bit-rate tick and enable, and discards the power-up warm-up samples.
- Converts accepted 24-bit samples to 16-bit and delivers them downstream with valid/ready framing (frame_start/frame_end).
- Sits between the microphone receiver and the feature-extraction front end.
- Start/stop are single-cycle commands from the system controller.

Parameters:
- DIV, 8: clk cycles per mic_tick period (>=2); mic_tick is 1 cycle high every DIV cycles.
- WARMUP, 2048: number of mic samples discarded after start (>=1).
- FRAME_LEN, 256: samples per output frame (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  pulse: begin capture (ignored unless IDLE)
- stop  in  1  pulse: end capture
- mic_enable  out  1  enable to receiver
- mic_tick  out  1  bit-rate tick to receiver
- mic_data  in  24  sample from receiver, two's complement
- mic_rdy  in  1  1-cycle sample strobe from receiver
- smp  out  16  output sample
- smp_valid  out  1  smp holds a sample
- smp_ready  in  1  downstream accepts
- frame_start  out  1  qualifies smp: first sample of frame
- frame_end  out  1  qualifies smp: last sample of frame
- busy  out  1  state != IDLE
- overrun  out  1  sticky: sample dropped

Behaviour:
- Reset: state=IDLE; tick counter=0; warm-up and frame counters=0; all outputs 0 (smp=0, smp_valid=0, overrun=0).
- Reset mid-operation aborts immediately; any held sample is lost.
- States:
  - IDLE: mic_enable=0, mic_tick=0.
    - start -> WARMUP. Clear overrun, warm-up counter, frame counter and tick counter.
  - WARMUP: mic_enable=1, ticks run. Each mic_rdy increments the warm-up counter; the sample is not output.
    - On the WARMUP-th mic_rdy -> RUN.
    - stop -> IDLE immediately.
  - RUN: mic_enable=1, ticks run. Each mic_rdy is captured into the holding register.
    - stop -> DRAIN, or -> IDLE directly if the frame counter=0 and smp_valid=0.
  - DRAIN: keeps running as RUN until the handshake that carries frame_end, then -> IDLE.
    - stop in DRAIN is ignored.
- Tick: counter 0..DIV-1, free-running while state != IDLE. mic_tick=1 when counter==DIV-1. Registered output.
- Conversion: smp = mic_data[23:8] (truncation, sign preserved). Captured one cycle after mic_rdy, so mic_rdy at cycle t gives smp_valid=1 at t+1.
- Holding register: single entry.
  - smp_valid drops the cycle after a handshake (smp_valid & smp_ready) unless a new sample is loaded the same cycle.
  - A handshake and mic_rdy in the same cycle: the new sample is loaded, no overrun.
  - mic_rdy while smp_valid=1 & smp_ready=0: the sample is dropped, overrun set (sticky until next start). The frame counter does not advance.
  - smp, frame_start and frame_end stay stable while smp_valid=1 & smp_ready=0.
- Framing:
  - The frame counter counts loaded samples 0..FRAME_LEN-1 and wraps.
  - frame_start=1 on the sample loaded at count 0; frame_end=1 on the sample loaded at count FRAME_LEN-1.
  - Frames are never truncated by stop.
- start while not IDLE: ignored.
- start and stop in the same cycle in IDLE: start wins, stop ignored.
- busy=1 in WARMUP/RUN/DRAIN.

Test Plan:
- Tick/warm-up: DIV=4, WARMUP=3, start, model returns mic_rdy every 40 cycles -> mic_tick every 4th cycle; first 3 samples produce no smp_valid; 4th sample 24'h123456 -> smp=16'h1234, smp_valid next cycle, frame_start=1.
- Framing: FRAME_LEN=4, smp_ready=1, samples 24'hFFFF00, 24'h800000, 24'h7FFFFF, 24'h000100 -> smp=FFFF, 8000, 7FFF, 0001; frame_start on first only, frame_end on fourth; 5th sample frame_start=1 again.
- Backpressure/overrun: smp_ready=0 across two mic_rdy -> first sample held stable, second dropped, overrun=1. Then smp_ready=1 -> held sample accepted; next sample keeps frame position (frame counter not advanced by drop). overrun stays 1 until next start.
- Stop mid-frame: FRAME_LEN=4, stop after 2nd sample accepted -> busy stays 1, mic_enable=1 until frame_end handshake of 4th sample, then IDLE, mic_enable=0, mic_tick=0.
- Stop in WARMUP and reset mid-RUN: stop during warm-up -> IDLE next cycle, no smp_valid. Reset asserted with smp_valid=1 -> all outputs 0 the cycle after rst; start afterwards repeats full warm-up.
- Simultaneous: handshake and mic_rdy in same cycle -> new sample loaded, smp_valid stays 1, overrun stays 0. start+stop in same cycle in IDLE -> enters WARMUP.
